// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation mode (angle -> cos/sin) and vectoring mode
// (x,y -> scaled magnitude/angle). One micro-rotation per enabled cycle, with a
// quadrant pre-rotation step, valid/ready handshakes on both sides, and a clock enable.
module cordic_engine #(
  parameter int INTEGER_WIDTH    = 4,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int ITERATIONS       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clk_en,
  input  logic                                      mode,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] x_in,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] y_in,
  input  logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] z_in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] x_out,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] y_out,
  output logic [INTEGER_WIDTH+FRACTIONAL_WIDTH-1:0] z_out,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      done
);

  localparam int  DW    = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int  IW    = DW + 2;  // two guard bits absorb CORDIC gain growth
  localparam int  TAB_N = 24;
  localparam real SCALE = 2.0 ** FRACTIONAL_WIDTH;

  localparam logic signed [IW-1:0] KINV        = IW'(longint'(0.6072529350 * SCALE));
  localparam logic signed [DW-1:0] HALF_PI     = DW'(longint'(1.5707963267948966 * SCALE));
  localparam logic signed [DW-1:0] NEG_HALF_PI = -HALF_PI;
  // The counter runs one step past the last micro-rotation; that step registers the outputs.
  localparam logic [4:0]           LAST_CNT    = 5'(ITERATIONS);

  function automatic real atan_val(input int i);
    case (i)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      12:      return 0.00024414062014936177;
      13:      return 0.00012207031189367021;
      14:      return 6.103515617420877e-05;
      15:      return 3.0517578115526096e-05;
      16:      return 1.5258789061315762e-05;
      17:      return 7.62939453110197e-06;
      18:      return 3.814697265606496e-06;
      19:      return 1.907348632810187e-06;
      20:      return 9.536743164059608e-07;
      21:      return 4.7683715820308884e-07;
      22:      return 2.3841857910155797e-07;
      23:      return 1.1920928955078068e-07;
      default: return 0.0;
    endcase
  endfunction

  // atan(2^-i) rounded to the fixed-point grid, packed entry i at bits [i*DW +: DW]
  function automatic logic [TAB_N*DW-1:0] gen_atan_tab();
    logic [TAB_N*DW-1:0] t;
    t = '0;
    for (int i = 0; i < TAB_N; i++) begin
      t[i*DW +: DW] = DW'(longint'(atan_val(i) * SCALE));
    end
    return t;
  endfunction

  localparam logic [TAB_N*DW-1:0] ATAN_TAB = gen_atan_tab();

  // Clamp the guard-bit internal value into the signed output range
  function automatic logic [DW-1:0] sat(input logic signed [IW-1:0] v);
    if ((&v[IW-1:DW-1]) || !(|v[IW-1:DW-1])) begin
      return v[DW-1:0];
    end else if (v[IW-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  typedef enum logic [1:0] {IDLE, PREROT, ITER, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_mode;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [DW-1:0] r_z;
  logic [4:0]           r_cnt;
  logic [DW-1:0]        r_x_out;
  logic [DW-1:0]        r_y_out;
  logic [DW-1:0]        r_z_out;

  logic [4:0]           w_idx;
  logic signed [IW-1:0] w_x_shift;
  logic signed [IW-1:0] w_y_shift;
  logic signed [DW-1:0] w_atan;
  logic                 w_dir_pos;
  logic signed [IW-1:0] w_x_rot;
  logic signed [IW-1:0] w_y_rot;
  logic signed [DW-1:0] w_z_rot;
  logic                 w_last;

  assign w_last    = (r_cnt == LAST_CNT);
  assign w_idx     = (r_cnt < 5'(TAB_N)) ? r_cnt : 5'd0;
  assign w_atan    = $signed(ATAN_TAB[w_idx*DW +: DW]);
  assign w_x_shift = r_x >>> r_cnt;
  assign w_y_shift = r_y >>> r_cnt;
  // Rotation steers z toward 0; vectoring steers y toward 0
  assign w_dir_pos = r_mode ? r_y[IW-1] : ~r_z[DW-1];
  assign w_x_rot   = w_dir_pos ? (r_x - w_y_shift) : (r_x + w_y_shift);
  assign w_y_rot   = w_dir_pos ? (r_y + w_x_shift) : (r_y - w_x_shift);
  assign w_z_rot   = w_dir_pos ? (r_z - w_atan) : (r_z + w_atan);

  assign x_out = r_x_out;
  assign y_out = r_y_out;
  assign z_out = r_z_out;

  // State register, frozen while clk_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = PREROT;
      end
      PREROT: w_state_next = ITER;
      ITER: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done         = clk_en;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, quadrant pre-rotation, micro-rotations, output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
    end else if (clk_en) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mode <= mode;
            r_cnt  <= '0;
            if (mode) begin
              r_x <= IW'($signed(x_in));
              r_y <= IW'($signed(y_in));
              r_z <= '0;
            end else begin
              r_x <= KINV;
              r_y <= '0;
              r_z <= z_in;
            end
          end
        end
        PREROT: begin
          if (!r_mode) begin
            if (r_z > HALF_PI) begin
              r_x <= '0;
              r_y <= KINV;
              r_z <= r_z - HALF_PI;
            end else if (r_z < NEG_HALF_PI) begin
              r_x <= '0;
              r_y <= -KINV;
              r_z <= r_z + HALF_PI;
            end
          end else if (r_x[IW-1]) begin
            // Left half-plane: rotate by -/+90 deg so CORDIC starts in its convergence range
            if (!r_y[IW-1]) begin
              r_x <= r_y;
              r_y <= -r_x;
              r_z <= HALF_PI;
            end else begin
              r_x <= -r_y;
              r_y <= r_x;
              r_z <= NEG_HALF_PI;
            end
          end else begin
            r_z <= '0;
          end
        end
        ITER: begin
          if (w_last) begin
            r_x_out <= sat(r_x);
            r_y_out <= sat(r_y);
            r_z_out <= r_z;
          end else begin
            r_x   <= w_x_rot;
            r_y   <= w_y_rot;
            r_z   <= w_z_rot;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
